branch_predictor: RTL
=====================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter BTB_ENTRIES, default 64, meaning number of direct-mapped BTB entries (power of two, 4..1024).
REQ-002 SHALL have parameter PHT_ENTRIES, default 256, meaning number of 2-bit PHT counters (power of two, 4..4096).
REQ-003 SHALL have port clk_i, input, 1 bit, the single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n_i, input, 1 bit, reset that is synchronous and active-low.
REQ-005 SHALL have port fetch_valid_i, input, 1 bit, fetch PC valid this cycle.
REQ-006 SHALL have port fetch_pc_i, input, 32 bits, fetch PC to predict.
REQ-007 SHALL have port pred_taken_o, output, 1 bit, predicted direction.
REQ-008 SHALL have port pred_tgt_o, output, 32 bits, predicted next PC.
REQ-009 SHALL have port ready_o, output, 1 bit, tables initialised.
REQ-010 SHALL have port update_pht_i, input, 1 bit, resolved branch in execute slot 0.
REQ-011 SHALL have port update_btb_i, input, 1 bit, BTB target write request.
REQ-012 SHALL have port upd_pc_i, input, 32 bits, PC of the resolved branch.
REQ-013 SHALL have port corr_taken_i, input, 1 bit, resolved direction.
REQ-014 SHALL have port corr_tgt_i, input, 32 bits, resolved target.

Function
REQ-015 SHALL produce a prediction with 1-cycle latency: pred_* in cycle N+1 reflect fetch_pc_i and table state sampled at the cycle-N edge.
REQ-016 SHALL form the BTB index as pc[log2(BTB_ENTRIES)+1:2] and the tag as pc[31:log2(BTB_ENTRIES)+2], with one valid bit per entry.
REQ-017 SHALL form the PHT index as pc[log2(PHT_ENTRIES)+1:2] (bimodal).
REQ-018 SHALL set pred_taken_o = fetch_valid_i(registered) AND BTB hit AND PHT counter[1].
REQ-019 SHALL set pred_tgt_o = BTB target when pred_taken_o, else registered fetch_pc + 4 (32-bit wrap).
REQ-020 SHALL, on update_pht_i, use a 2-bit saturating counter: increment if corr_taken_i, stop at 3; decrement otherwise, stop at 0.
REQ-021 SHALL, on update_btb_i, write tag, target = corr_tgt_i and valid = 1 at upd_pc_i's index; an existing entry is overwritten.
REQ-022 SHALL use read-before-write: a lookup and an update to the same index in the same cycle return the pre-update value.
REQ-023 SHALL have an FSM with states INIT and RUN. INIT sweeps a counter over 0..max(BTB,PHT)-1, one entry per cycle, writing PHT = 2'b01 and BTB valid = 0. It goes to RUN after the last index.
REQ-024 SHALL hold ready_o = 0 and pred_taken_o = 0 and ignore updates during INIT.
REQ-025 SHALL ignore update_btb_i when update_pht_i = 0; ignoring it is legal behaviour and not an error.

Reset
REQ-026 SHALL, while rst_n_i = 0 at the edge, enter INIT with sweep counter 0, and drive ready_o = 0, pred_taken_o = 0, pred_tgt_o = 0, GHR = 0.
REQ-027 SHALL treat reset asserted mid-sweep or in RUN identically: the sweep restarts at index 0.

Configuration
REQ-028 SHALL provide macro BRANCH_PREDICTOR_GSHARE_EN to compile in the gshare feature.
- Defined: adds an 8-bit GHR, shifted left with corr_taken_i on each update_pht_i. The PHT index becomes bimodal index XOR GHR (zero-extended or truncated to the index width). The GHR is sampled for lookup at the same edge as the PC.
- Undefined: no GHR; pure bimodal indexing.

Structure
REQ-029 SHALL place the counter encodings (SNT=0, WNT=1, WT=2, ST=3), the FSM state type and the INIT value in the shared core definitions package/header.
REQ-030 SHALL implement the saturating counter update as sub-module sat_counter2 (combinational next-state).

Verification
REQ-031 SHALL cover: reset, then 300 cycles -> ready_o = 0 for exactly 256 cycles after reset release, then 1; pred_taken_o = 0 throughout.
REQ-032 SHALL cover: update pc=0x100, taken, tgt=0x200, with both update strobes set; then fetch 0x100 -> pred_taken_o = 1, pred_tgt_o = 0x200 one cycle later.
REQ-033 SHALL cover: 3 not-taken updates at 0x100 after REQ-032 -> counter 0, pred_taken_o = 0, pred_tgt_o = 0x104.
REQ-034 SHALL cover: BTB alias, write 0x100 then 0x200 (same index, different tag) -> fetch 0x100 gives pred_taken_o = 0.
REQ-035 SHALL cover: a same-cycle fetch and update at 0x100 (counter 1 -> 2) -> that prediction is not-taken; the next fetch is taken.
REQ-036 SHALL cover: reset asserted mid-sweep at cycle 100 -> ready_o rises 256 cycles after the second release; fetch_pc=0xFFFFFFFC not taken -> pred_tgt_o = 0x00000000.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// rtl/branch_predictor_pkg.sv - shared counter encodings, FSM states and init value for the branch predictor
package branch_predictor_pkg;

    // 2-bit bimodal counter encodings
    typedef enum logic [1:0] {
        CTR_SNT = 2'd0,
        CTR_WNT = 2'd1,
        CTR_WT  = 2'd2,
        CTR_ST  = 2'd3
    } ctr_t;

    // table initialisation sweep versus normal operation
    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // every PHT counter starts weakly not-taken
    localparam ctr_t CTR_INIT = CTR_WNT;

    // global history length used when gshare indexing is compiled in
    localparam int GHR_W = 8;

endpackage

// File: rtl/sat_counter2.sv
// rtl/sat_counter2.sv - combinational next-state of a 2-bit saturating counter
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       taken,
    output logic [1:0] ctr_next
);

    // step toward the resolved direction, holding at either end
    always_comb begin
        ctr_next = ctr;
        if (taken) begin
            if (ctr != CTR_ST) ctr_next = ctr + 2'd1;
        end else begin
            if (ctr != CTR_SNT) ctr_next = ctr - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - BTB + bimodal PHT predictor, optional gshare via BRANCH_PREDICTOR_GSHARE_EN
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int BTB_ENTRIES = 64,
    parameter int PHT_ENTRIES = 256
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        fetch_valid_i,
    input  logic [31:0] fetch_pc_i,
    output logic        pred_taken_o,
    output logic [31:0] pred_tgt_o,
    output logic        ready_o,
    input  logic        update_pht_i,
    input  logic        update_btb_i,
    input  logic [31:0] upd_pc_i,
    input  logic        corr_taken_i,
    input  logic [31:0] corr_tgt_i
);

    localparam int BTB_IDX_W = $clog2(BTB_ENTRIES);
    localparam int PHT_IDX_W = $clog2(PHT_ENTRIES);
    localparam int TAG_W     = 32 - BTB_IDX_W - 2;
    localparam int SWEEP_N   = (BTB_ENTRIES > PHT_ENTRIES) ? BTB_ENTRIES : PHT_ENTRIES;
    // one spare bit so range checks against either table size never fold to constants
    localparam int SWEEP_W   = $clog2(SWEEP_N) + 1;

    logic             btb_valid [BTB_ENTRIES];
    logic [TAG_W-1:0] btb_tag   [BTB_ENTRIES];
    logic [31:0]      btb_tgt   [BTB_ENTRIES];
    logic [1:0]       pht       [PHT_ENTRIES];

    state_t               state_q, state_d;
    logic [SWEEP_W-1:0]   sweep_cnt;
    logic [31:0]          sweep_ext;
    logic                 sweep_last;
    logic                 run;

    logic [BTB_IDX_W-1:0] fetch_btb_idx, upd_btb_idx;
    logic [PHT_IDX_W-1:0] fetch_pht_idx, upd_pht_idx;
    logic [TAG_W-1:0]     fetch_tag, upd_tag;
    logic                 btb_hit;
    logic [1:0]           fetch_ctr;
    logic [1:0]           upd_ctr_next;
    logic                 taken_d;
    logic [31:0]          tgt_d;
    logic                 pred_taken_q;
    logic [31:0]          pred_tgt_q;

    logic                 unused_pc_bits;
    assign unused_pc_bits = ^{fetch_pc_i[1:0], upd_pc_i[1:0]};

    assign sweep_ext  = 32'(sweep_cnt);
    assign sweep_last = (sweep_ext == 32'(SWEEP_N - 1));
    assign run        = (state_q == S_RUN);

    assign fetch_btb_idx = fetch_pc_i[BTB_IDX_W+1:2];
    assign upd_btb_idx   = upd_pc_i[BTB_IDX_W+1:2];
    assign fetch_tag     = fetch_pc_i[31:BTB_IDX_W+2];
    assign upd_tag       = upd_pc_i[31:BTB_IDX_W+2];

`ifdef BRANCH_PREDICTOR_GSHARE_EN
    logic [GHR_W-1:0]     ghr_q;
    logic [PHT_IDX_W-1:0] ghr_idx;

    // resize the history to the PHT index width (zero-extend or truncate)
    always_comb begin
        ghr_idx = '0;
        for (int i = 0; i < PHT_IDX_W; i++) begin
            if (i < GHR_W) ghr_idx[i] = ghr_q[i % GHR_W];
        end
    end

    // global history shifts in each resolved direction
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            ghr_q <= '0;
        end else if (run && update_pht_i) begin
            ghr_q <= {ghr_q[GHR_W-2:0], corr_taken_i};
        end
    end

    assign fetch_pht_idx = fetch_pc_i[PHT_IDX_W+1:2] ^ ghr_idx;
    assign upd_pht_idx   = upd_pc_i[PHT_IDX_W+1:2] ^ ghr_idx;
`else
    assign fetch_pht_idx = fetch_pc_i[PHT_IDX_W+1:2];
    assign upd_pht_idx   = upd_pc_i[PHT_IDX_W+1:2];
`endif

    sat_counter2 u_sat_counter2 (
        .ctr      (pht[upd_pht_idx]),
        .taken    (corr_taken_i),
        .ctr_next (upd_ctr_next)
    );

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) state_q <= S_INIT;
        else          state_q <= state_d;
    end

    // leave the sweep once the last index has been written
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT:  if (sweep_last) state_d = S_RUN;
            S_RUN:   state_d = S_RUN;
            default: state_d = S_INIT;
        endcase
    end

    // sweep index, restarted by any reset
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sweep_cnt <= '0;
        end else if (state_q == S_INIT && !sweep_last) begin
            sweep_cnt <= sweep_cnt + 1'b1;
        end
    end

    // table writes: init sweep, or resolved-branch updates once running
    always_ff @(posedge clk_i) begin
        if (rst_n_i && state_q == S_INIT) begin
            if (sweep_ext < BTB_ENTRIES) btb_valid[sweep_cnt[BTB_IDX_W-1:0]] <= 1'b0;
            if (sweep_ext < PHT_ENTRIES) pht[sweep_cnt[PHT_IDX_W-1:0]] <= CTR_INIT;
        end else if (rst_n_i && run && update_pht_i) begin
            pht[upd_pht_idx] <= upd_ctr_next;
            if (update_btb_i) begin
                btb_valid[upd_btb_idx] <= 1'b1;
                btb_tag[upd_btb_idx]   <= upd_tag;
                btb_tgt[upd_btb_idx]   <= corr_tgt_i;
            end
        end
    end

    // lookup reads the pre-update table contents
    always_comb begin
        btb_hit   = btb_valid[fetch_btb_idx] && (btb_tag[fetch_btb_idx] == fetch_tag);
        fetch_ctr = pht[fetch_pht_idx];
        taken_d   = fetch_valid_i && run && btb_hit && fetch_ctr[1];
        tgt_d     = taken_d ? btb_tgt[fetch_btb_idx] : (fetch_pc_i + 32'd4);
    end

    // prediction register gives the one-cycle lookup latency
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            pred_taken_q <= 1'b0;
            pred_tgt_q   <= '0;
        end else begin
            pred_taken_q <= taken_d;
            pred_tgt_q   <= tgt_d;
        end
    end

    assign pred_taken_o = pred_taken_q;
    assign pred_tgt_o   = pred_tgt_q;
    assign ready_o      = run;

endmodule
